tenkey_debounce: RTL and testbench

//  Front end for the electronic lock. Converts 10 raw, bouncing, asynchronous push-button

---
 rtl/tenkey_debounce_pkg.sv | 30 +++
 rtl/tenkey_debounce_sync2.sv | 27 ++
 rtl/tenkey_debounce.sv | 135 +++++++++++++
 tb/tb_tenkey_debounce.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tenkey_debounce_pkg.sv
// Shared definitions for the ten-key debounce front end.
//   state_t    : FSM state encoding, exposed on the top-level debug port
//   NKEYS_DEF  : default number of keys
//   MAX_KEYS   : widest key vector the helper functions accept
//   is_onehot  : exactly one bit set
//   is_multi   : two or more bits set
package tenkey_debounce_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        QUAL = 3'd1,
        HELD = 3'd2,
        REL  = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam int NKEYS_DEF = 10;
    localparam int MAX_KEYS  = 32;

    // v & (v - 1) clears the lowest set bit; the result is zero
    // only when at most one bit was set.
    function automatic logic is_onehot(input logic [MAX_KEYS-1:0] v);
        return (v != '0) && ((v & (v - MAX_KEYS'(1))) == '0);
    endfunction

    function automatic logic is_multi(input logic [MAX_KEYS-1:0] v);
        return (v & (v - MAX_KEYS'(1))) != '0;
    endfunction

endpackage

// File: rtl/tenkey_debounce_sync2.sv
// Two-flop synchroniser for a bundle of asynchronous inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low clear of both stages
//   d     : asynchronous input bits
//   q     : synchronised copy of d, two clk edges later
module tenkey_debounce_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tenkey_debounce.sv
// Ten-key front end for the electronic lock: synchronises, debounces and
// qualifies one key at a time, rejecting (and flagging) multi-key presses.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   sw_raw    : raw active-high buttons, asynchronous, may bounce
//   tenkey    : one-hot qualified key while held, zero otherwise
//   key_press : one-cycle pulse on the first cycle tenkey is non-zero
//   multi_err : high while more than one key is being seen
//   dbg_state : current FSM state
//
// Handshake: none. tenkey/key_press/multi_err are plain registered levels
// that the lock core samples every clk; there is no back-pressure.
module tenkey_debounce
    import tenkey_debounce_pkg::*;
#(
    parameter int NKEYS     = NKEYS_DEF,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NKEYS-1:0] sw_raw,
    output logic [NKEYS-1:0] tenkey,
    output logic             key_press,
    output logic             multi_err,
    output state_t           dbg_state
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [NKEYS-1:0]    sync;
    logic [MAX_KEYS-1:0] sync_w;
    logic                sync_onehot;
    logic                sync_multi;
    logic                sync_zero;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [NKEYS-1:0]    cand;

    tenkey_debounce_sync2 #(
        .W (NKEYS)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sw_raw),
        .q     (sync)
    );

    assign sync_w      = MAX_KEYS'(sync);
    assign sync_onehot = is_onehot(sync_w);
    assign sync_multi  = is_multi(sync_w);
    assign sync_zero   = (sync == '0);
    assign dbg_state   = state;

    // Outputs are registered alongside the state so that tenkey, key_press
    // and multi_err always agree with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            tenkey    <= '0;
            key_press <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            key_press <= 1'b0;
            if (sync_multi) begin
                // Multi-key rejection overrides every state.
                state     <= ERR;
                cnt       <= '0;
                tenkey    <= '0;
                multi_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (sync_onehot) begin
                            cand  <= sync;
                            cnt   <= '0;
                            state <= QUAL;
                        end
                    end
                    QUAL: begin
                        if (sync == cand) begin
                            if (cnt == CNT_LAST) begin
                                state     <= HELD;
                                tenkey    <= cand;
                                key_press <= 1'b1;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else if (sync_zero) begin
                            // A drop to zero abandons the candidate entirely.
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            // A different single key restarts qualification.
                            cand <= sync;
                            cnt  <= '0;
                        end
                    end
                    HELD: begin
                        // Any change, including a new key, forces a full
                        // release before another key can qualify.
                        if (sync != cand) begin
                            state  <= REL;
                            cnt    <= '0;
                            tenkey <= '0;
                        end
                    end
                    REL, ERR: begin
                        if (sync_zero) begin
                            if (cnt == CNT_LAST) begin
                                state     <= IDLE;
                                cnt       <= '0;
                                multi_err <= 1'b0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        cnt       <= '0;
                        tenkey    <= '0;
                        multi_err <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tenkey_debounce.sv
module tb_tenkey_debounce;
    import tenkey_debounce_pkg::*;

    localparam int NK = 10;
    localparam int DB = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] sw_raw = '0;
    logic [NK-1:0] tenkey;
    logic          key_press;
    logic          multi_err;
    state_t        dbg_state;

    always #5 clk = ~clk;

    tenkey_debounce #(
        .NKEYS     (NK),
        .DB_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_raw    (sw_raw),
        .tenkey    (tenkey),
        .key_press (key_press),
        .multi_err (multi_err),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // Run-length view of the rules: a key is accepted once the same single
    // key has been seen for DB+1 consecutive samples since the block last
    // became idle; after any release or multi-key event, DB consecutive zero
    // samples are needed before the block is idle again.
    // m_mode: 0 = waiting for a key, 1 = key held, 2 = releasing, 3 = error
    logic [NK-1:0] m_s1 = '0, m_s2 = '0, m_key = '0, m_run_val = '0, sv;
    int            m_mode = 0, m_run = 0, m_zeros = 0;
    logic [NK-1:0] e_tenkey = '0;
    logic          e_press = 1'b0, e_err = 1'b0, e_idle = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_key = '0; m_run_val = '0;
            m_mode = 0; m_run = 0; m_zeros = 0;
            e_tenkey = '0; e_press = 1'b0; e_err = 1'b0; e_idle = 1'b1;
        end else begin
            sv = m_s2;
            m_s2 = m_s1;
            m_s1 = sw_raw;
            e_press = 1'b0;
            if ($countones(sv) > 1) begin
                m_mode = 3;
                m_zeros = 0;
            end else begin
                case (m_mode)
                    0: begin
                        if (sv == '0) m_run = 0;
                        else if (m_run > 0 && sv == m_run_val) m_run++;
                        else begin m_run_val = sv; m_run = 1; end
                        if (m_run == DB + 1) begin
                            m_mode = 1; m_key = sv; e_press = 1'b1;
                        end
                    end
                    1: if (sv != m_key) begin m_mode = 2; m_zeros = 0; end
                    default: begin
                        if (sv == '0) begin
                            m_zeros++;
                            if (m_zeros == DB) begin m_mode = 0; m_run = 0; end
                        end else m_zeros = 0;
                    end
                endcase
            end
            e_tenkey = (m_mode == 1) ? m_key : '0;
            e_err    = (m_mode == 3);
            e_idle   = (m_mode == 0) && (m_run == 0);
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [NK-1:0] v);
        @(negedge clk);
        sw_raw = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        sw_raw = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tenkey !== '0 || key_press !== 1'b0 || multi_err !== 1'b0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_state got tenkey=%h press=%b err=%b state=%0d exp 000/0/0/IDLE",
                     tenkey, key_press, multi_err, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_press();
        drive(10'h080);
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++;
            if (tenkey !== ((e >= 7) ? 10'h080 : 10'h000) || key_press !== 1'(e == 7)) begin
                failures++;
                $display("FAIL clean_press edge=%0d got tenkey=%h press=%b", e, tenkey, key_press);
            end
            checks++;
            if (tenkey !== e_tenkey || key_press !== e_press || multi_err !== e_err) begin
                failures++;
                $display("FAIL clean_press_model edge=%0d got %h/%b/%b exp %h/%b/%b",
                         e, tenkey, key_press, multi_err, e_tenkey, e_press, e_err);
            end
        end
        drive('0);
        for (int e = 1; e <= 9; e++) begin
            tick();
            checks++;
            if (tenkey !== ((e >= 3) ? 10'h000 : 10'h080) || key_press !== 1'b0 ||
                (dbg_state == IDLE) !== (e >= 7)) begin
                failures++;
                $display("FAIL clean_release edge=%0d got tenkey=%h press=%b state=%0d",
                         e, tenkey, key_press, dbg_state);
            end
        end
    endtask

    task automatic test_bounce();
        int presses = 0;
        for (int i = 0; i < 10; i++) begin
            drive(((i / 2) % 2 == 1) ? 10'h004 : 10'h000);
            tick();
            checks++;
            if (tenkey !== '0 || key_press !== 1'b0 || key_press !== e_press) begin
                failures++;
                $display("FAIL bounce_phase cycle=%0d got tenkey=%h press=%b", i, tenkey, key_press);
            end
        end
        drive(10'h004);
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (key_press) presses++;
            checks++;
            if (key_press !== 1'(e == 7) || tenkey !== e_tenkey || key_press !== e_press) begin
                failures++;
                $display("FAIL bounce_steady edge=%0d got tenkey=%h press=%b exp %h/%b",
                         e, tenkey, key_press, e_tenkey, e_press);
            end
        end
        checks++;
        if (presses !== 1) begin
            failures++;
            $display("FAIL bounce_press_count got=%0d exp=1", presses);
        end
        drive('0);
        repeat (8) tick();
    endtask

    task automatic test_multi_key();
        drive(10'h003);
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (multi_err !== 1'(e >= 3) || tenkey !== '0 || multi_err !== e_err) begin
                failures++;
                $display("FAIL multi_hold edge=%0d got err=%b tenkey=%h", e, multi_err, tenkey);
            end
        end
        drive('0);
        for (int e = 1; e <= 9; e++) begin
            tick();
            checks++;
            if (multi_err !== 1'(e < 6) || tenkey !== '0 || multi_err !== e_err ||
                (dbg_state == IDLE) !== e_idle) begin
                failures++;
                $display("FAIL multi_release edge=%0d got err=%b tenkey=%h state=%0d",
                         e, multi_err, tenkey, dbg_state);
            end
        end
    endtask

    task automatic test_key_change();
        int waited = 0;
        drive(10'h001);
        repeat (8) tick();
        checks++;
        if (tenkey !== 10'h001) begin
            failures++;
            $display("FAIL key_change_first got=%h exp=001", tenkey);
        end
        drive(10'h002);
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (tenkey !== ((e >= 3) ? 10'h000 : 10'h001) || key_press !== 1'b0 ||
                tenkey !== e_tenkey) begin
                failures++;
                $display("FAIL key_change_switch edge=%0d got tenkey=%h press=%b", e, tenkey, key_press);
            end
        end
        drive('0);
        do begin
            tick();
            waited++;
        end while (dbg_state != IDLE && waited < 20);
        checks++;
        if (dbg_state != IDLE || waited != 6) begin
            failures++;
            $display("FAIL key_change_idle got waited=%0d state=%0d exp 6/IDLE", waited, dbg_state);
        end
        drive(10'h002);
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (tenkey !== ((e >= 7) ? 10'h002 : 10'h000) || key_press !== 1'(e == 7)) begin
                failures++;
                $display("FAIL key_change_fresh edge=%0d got tenkey=%h press=%b", e, tenkey, key_press);
            end
        end
        drive('0);
        repeat (8) tick();
    endtask

    task automatic test_reset_mid();
        drive(10'h200);
        repeat (8) tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tenkey !== '0 || multi_err !== 1'b0 || key_press !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async got tenkey=%h err=%b press=%b", tenkey, multi_err, key_press);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (key_press !== 1'(e == 7) || tenkey !== ((e >= 7) ? 10'h200 : 10'h000) ||
                tenkey !== e_tenkey) begin
                failures++;
                $display("FAIL reset_mid_requal edge=%0d got tenkey=%h press=%b", e, tenkey, key_press);
            end
        end
        drive('0);
        repeat (8) tick();
    endtask

    task automatic test_release_bounce();
        logic [NK-1:0] rel_pat [12];
        rel_pat = '{10'h000, 10'h000, 10'h080, 10'h000, 10'h000, 10'h000,
                    10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
        drive(10'h080);
        repeat (8) tick();
        for (int e = 1; e <= 12; e++) begin
            drive(rel_pat[e-1]);
            tick();
            checks++;
            if (key_press !== 1'b0 || tenkey !== ((e >= 3) ? 10'h000 : 10'h080) ||
                (dbg_state == IDLE) !== (e >= 9) || (dbg_state == IDLE) !== e_idle) begin
                failures++;
                $display("FAIL release_bounce edge=%0d got tenkey=%h press=%b state=%0d",
                         e, tenkey, key_press, dbg_state);
            end
        end
    endtask

    task automatic test_random();
        logic [NK-1:0] v;
        int sel;
        for (int seg = 0; seg < 250; seg++) begin
            sel = $urandom_range(0, 99);
            if (sel < 35)      v = '0;
            else if (sel < 85) v = NK'(1) << $urandom_range(0, NK - 1);
            else               v = (NK'(1) << $urandom_range(0, NK - 1)) |
                                   (NK'(1) << $urandom_range(0, NK - 1));
            drive(v);
            repeat ($urandom_range(1, 10)) begin
                tick();
                checks++;
                if (tenkey !== e_tenkey || key_press !== e_press || multi_err !== e_err ||
                    (dbg_state == IDLE) !== e_idle || $countones(tenkey) > 1) begin
                    failures++;
                    $display("FAIL random seg=%0d got %h/%b/%b/%0d exp %h/%b/%b idle=%b",
                             seg, tenkey, key_press, multi_err, dbg_state,
                             e_tenkey, e_press, e_err, e_idle);
                end
            end
        end
        drive('0);
        repeat (10) tick();
        checks++;
        if (dbg_state !== IDLE || tenkey !== '0 || multi_err !== 1'b0) begin
            failures++;
            $display("FAIL random_settle got state=%0d tenkey=%h err=%b", dbg_state, tenkey, multi_err);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_key();
        test_key_change();
        test_reset_mid();
        test_release_bounce();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
